hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard-controller FSM states, default multiplier
// occupancy and register index width.
package cpu_pkg;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_e;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned REG_W       = 5;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: taken-branch flush, load-use stall and multi-cycle
// MUL sequencing. Define HAZARD_CTRL_PERF_EN to add stall/flush event counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D_valid,
  input  logic [REG_W-1:0] D_ra,
  input  logic [REG_W-1:0] D_rb,
  input  logic             D_mul,
  input  logic             E_ld,
  input  logic [REG_W-1:0] E_rd,
  input  logic             E_brn_taken,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_flush,
  output logic             E_bubble,
  output logic             mul_start,
  output logic             mul_done,
  output logic             mul_abort,
  output logic             busy
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  assign load_use = D_valid && E_ld && (E_rd != '0) && ((E_rd == D_ra) || (E_rd == D_rb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst_n so they read 0 while reset is held, even with
  // a taken branch on the inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_flush   = 1'b0;
    E_bubble  = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    mul_abort = 1'b0;
    busy      = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (E_brn_taken) begin
            D_flush  = 1'b1;
            E_bubble = 1'b1;
          end else if (load_use) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
          end else if (D_valid && D_mul) begin
            mul_start = 1'b1;
            F_stall   = 1'b1;
            D_stall   = 1'b1;
            E_bubble  = 1'b1;
            state_d   = MUL_BUSY;
            cnt_d     = CNT_INIT;
          end
        end
        MUL_BUSY: begin
          busy = 1'b1;
          if (E_brn_taken) begin
            mul_abort = 1'b1;
            D_flush   = 1'b1;
            E_bubble  = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else if (cnt_q != '0) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
            cnt_d    = cnt_q - 4'd1;
          end else begin
            mul_done = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (F_stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (D_flush),
    .count (flush_cnt)
  );
`endif

endmodule
